alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between up to NUM_REQ requesters. Typical requesters: the execute stage, branch-target calculation and the load/store address generator.
- Each requester has a valid/ready request channel and a registered valid/ready response channel.
- Arbitration is round-robin. At most one operation issues per cycle.
- The block drives the `alu` ports directly and captures `alu`'s result into a per-requester response register.

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..8.
- TAG_W, 4: width of the opaque tag returned with each result.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted this cycle
- req_src_a  in  NUM_REQ x 32  operand A per requester
- req_src_b  in  NUM_REQ x 32  operand B per requester
- req_op  in  NUM_REQ x alu_op_e  operation per requester
- req_tag  in  NUM_REQ x TAG_W  tag per requester
- rsp_valid  out  NUM_REQ  result held for requester
- rsp_ready  in  NUM_REQ  requester consumes result
- rsp_result  out  NUM_REQ x 32  registered ALU result
- rsp_tag  out  NUM_REQ x TAG_W  tag of the held result
- alu_src_a  out  32  to alu src_a
- alu_src_b  out  32  to alu src_b
- alu_op  out  alu_op_e  to alu alu_op
- alu_result  in  32  from alu result

Behaviour:
- State:
  - ptr: log2(NUM_REQ) bits, round-robin pointer.
  - Per requester: rsp_valid, rsp_result, rsp_tag registers.
- Reset (sync, reset=1 at edge): ptr=0, all rsp_valid=0, rsp_result=0, rsp_tag=0. While reset is high, req_ready=0 and the ALU drive is idle.
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full response slot may accept a new request in the same cycle it drains.
- Grant (combinational):
  - The first eligible index, searching ptr, ptr+1, … modulo NUM_REQ.
  - At most one grant per cycle.
  - req_ready[i] = grant[i] && !reset. req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- ALU drive:
  - On grant: alu_src_a/src_b/op = the granted requester's operands.
  - With no grant: alu_src_a=0, alu_src_b=0, alu_op=ALU_ADD.
- Capture: on fire (req_valid[i] && req_ready[i]) at edge N:
  - rsp_result[i] <= alu_result.
  - rsp_tag[i] <= req_tag[i].
  - rsp_valid[i] <= 1.
  - Latency: the result is visible in cycle N+1.
- Drain: rsp_valid[i] && rsp_ready[i] with no new fire to i → rsp_valid[i] <= 0. Drain and refill in the same cycle → rsp_valid stays 1 and the data is replaced.
- Response hold: rsp_result and rsp_tag stay stable while rsp_valid=1 and rsp_ready=0.
- Pointer:
  - After a grant to i: ptr <= (i+1) mod NUM_REQ.
  - No grant: ptr unchanged.
  - Guarantees no starvation: each eligible requester is served within NUM_REQ cycles.
- Throughput: one op per cycle in aggregate. A single requester with rsp_ready held 1 gets back-to-back issue every cycle.
- Backpressure: requester i with rsp_valid=1 and rsp_ready=0 is ineligible, and the pointer skips it. Other requesters are unaffected.
- Withdrawal: deasserting req_valid before a grant is allowed and has no side effect.
- Reset mid-operation: pending responses are discarded (rsp_valid=0 next cycle). Any request presented during the reset cycle is not accepted.
- Ops: all alu_op_e values pass through unmodified. Result semantics are those of the `alu` module.
- Assertions (bench):
  - onehot0(req_ready).
  - No fire to i while rsp_valid[i] && !rsp_ready[i].
  - rsp_result stable under stall.

Test Plan:
1. Reset then single request: req0 ADD 5+7 tag 3, rsp_ready0=1 → req_ready0=1 in the same cycle; next cycle rsp_valid0=1, rsp_result0=12, rsp_tag0=3; following cycle rsp_valid0=0.
2. Contention: req0 and req1 valid every cycle with rsp_ready=1, NUM_REQ=2 → grants alternate 0,1,0,1 starting with 0 after reset. Each response carries its own op's result: req0 SUB 10-3=7, req1 SRA 0x80000000>>>4=0xF8000000.
3. Backpressure: rsp_ready0=0 after the first result 0x1 (SLT -1<0) while req0 stays valid → req_ready0=0 and rsp_result0 is held at 1 for 5 cycles. req1 is granted every cycle meanwhile. Raising rsp_ready0 → req0 is regranted in that cycle (drain+refill) and rsp_valid0 stays 1.
4. Back-to-back single requester: req1 issues XOR, SLL(1<<31), SLTU(1<0) on consecutive cycles → responses 0x..., 0x80000000, 0 in consecutive cycles with matching tags and no bubbles.
5. Reset mid-operation: rsp_valid0=1 and rsp_valid1=1 pending, assert reset one cycle → all rsp_valid=0 and req_ready=0 during reset. Afterwards ptr=0: with both requesting, req0 is granted first.
6. Fairness, NUM_REQ=4: all four requesters valid continuously → each is granted exactly once per 4-cycle window. The ALU drive is idle (0, 0, ALU_ADD) on cycles with no request.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Latency: a result is registered one cycle after the request is accepted.
// Backpressure: a requester holding an unconsumed result is skipped until it drains.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module alu
  import alu_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] result
);
  logic [4:0] shamt;
  assign shamt = src_b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = src_a + src_b;
      ALU_SUB:  result = src_a - src_b;
      ALU_SLL:  result = src_a << shamt;
      ALU_SLT:  result = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: result = {31'd0, src_a < src_b};
      ALU_XOR:  result = src_a ^ src_b;
      ALU_SRL:  result = src_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(src_a) >>> shamt);
      ALU_OR:   result = src_a | src_b;
      ALU_AND:  result = src_a & src_b;
      default:  result = '0;
    endcase
  end
endmodule

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic    [NUM_REQ-1:0]             req_valid,
  output logic    [NUM_REQ-1:0]             req_ready,
  input  logic    [NUM_REQ-1:0][31:0]       req_src_a,
  input  logic    [NUM_REQ-1:0][31:0]       req_src_b,
  input  alu_op_e [NUM_REQ-1:0]             req_op,
  input  logic    [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  output logic    [NUM_REQ-1:0]             rsp_valid,
  input  logic    [NUM_REQ-1:0]             rsp_ready,
  output logic    [NUM_REQ-1:0][31:0]       rsp_result,
  output logic    [NUM_REQ-1:0][TAG_W-1:0]  rsp_tag,
  output logic    [31:0]                    alu_src_a,
  output logic    [31:0]                    alu_src_b,
  output alu_op_e                           alu_op,
  input  logic    [31:0]                    alu_result
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0]              rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][31:0]        rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0][TAG_W-1:0]   rsp_tag_q, rsp_tag_d;

  logic [NUM_REQ-1:0] elig;
  logic               grant_found;
  logic               gnt_vld;
  logic [PTR_W-1:0]   grant_idx;

  // A full slot stays eligible when it drains this cycle, allowing drain+refill.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    sum         = '0;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign gnt_vld = grant_found && !reset;

  always_comb begin
    req_ready = '0;
    alu_src_a = '0;
    alu_src_b = '0;
    alu_op    = ALU_ADD;
    if (gnt_vld) begin
      req_ready[grant_idx] = 1'b1;
      alu_src_a            = req_src_a[grant_idx];
      alu_src_b            = req_src_b[grant_idx];
      alu_op               = req_op[grant_idx];
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    if (gnt_vld) begin
      ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = alu_result;
        rsp_tag_d[i]    = req_tag[i];
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 2-requester and a 4-requester instance, each driving a real alu.
// Accepted requests push hand-computed expectations; a negedge monitor pops and compares.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic    [1:0]       r2_valid, r2_ready, s2_valid, s2_ready;
  logic    [1:0][31:0] r2_a, r2_b, s2_result;
  alu_op_e [1:0]       r2_op;
  logic    [1:0][3:0]  r2_tag, s2_tag;
  logic    [31:0]      alu2_a, alu2_b, alu2_res;
  alu_op_e             alu2_op;

  logic    [3:0]       r4_valid, r4_ready, s4_valid, s4_ready;
  logic    [3:0][31:0] r4_a, r4_b, s4_result;
  alu_op_e [3:0]       r4_op;
  logic    [3:0][3:0]  r4_tag, s4_tag;
  logic    [31:0]      alu4_a, alu4_b, alu4_res;
  alu_op_e             alu4_op;

  alu_arbiter #(.NUM_REQ(2), .TAG_W(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(r2_valid), .req_ready(r2_ready), .req_src_a(r2_a), .req_src_b(r2_b),
    .req_op(r2_op), .req_tag(r2_tag),
    .rsp_valid(s2_valid), .rsp_ready(s2_ready), .rsp_result(s2_result), .rsp_tag(s2_tag),
    .alu_src_a(alu2_a), .alu_src_b(alu2_b), .alu_op(alu2_op), .alu_result(alu2_res)
  );
  alu u_alu2 (.alu_op(alu2_op), .src_a(alu2_a), .src_b(alu2_b), .result(alu2_res));

  alu_arbiter #(.NUM_REQ(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req_valid(r4_valid), .req_ready(r4_ready), .req_src_a(r4_a), .req_src_b(r4_b),
    .req_op(r4_op), .req_tag(r4_tag),
    .rsp_valid(s4_valid), .rsp_ready(s4_ready), .rsp_result(s4_result), .rsp_tag(s4_tag),
    .alu_src_a(alu4_a), .alu_src_b(alu4_b), .alu_op(alu4_op), .alu_result(alu4_res)
  );
  alu u_alu4 (.alu_op(alu4_op), .src_a(alu4_a), .src_b(alu4_b), .result(alu4_res));

  // Scoreboard slots: index d*4+i for dut d (0: two-way, 1: four-way), requester i.
  logic [31:0] exp_res [8];
  logic [3:0]  exp_tag [8];
  logic [35:0] sbq [8][$];
  logic        stall_v [8];
  logic [35:0] stall_d [8];

  alu_op_e     t4_op [3] = '{ALU_XOR, ALU_SLL, ALU_SLTU};
  logic [31:0] t4_a  [3] = '{32'hF0F0F0F0, 32'h00000001, 32'h00000001};
  logic [31:0] t4_b  [3] = '{32'h0FF00FF0, 32'd31, 32'h00000000};
  logic [31:0] t4_e  [3] = '{32'hFF00FF00, 32'h80000000, 32'h00000000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic req2(input int i, input logic v, input alu_op_e op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t, input logic [31:0] e);
    r2_valid[i] = v; r2_op[i] = op; r2_a[i] = a; r2_b[i] = b; r2_tag[i] = t;
    exp_res[i] = e; exp_tag[i] = t;
  endtask

  task automatic req4(input int i, input logic v, input alu_op_e op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] t, input logic [31:0] e);
    r4_valid[i] = v; r4_op[i] = op; r4_a[i] = a; r4_b[i] = b; r4_tag[i] = t;
    exp_res[4+i] = e; exp_tag[4+i] = t;
  endtask

  task automatic mon(input int d, input int n, input logic rst,
                     input logic [3:0] rv, input logic [3:0] rr,
                     input logic [3:0] rsv, input logic [3:0] rsr,
                     input logic [3:0][31:0] res, input logic [3:0][3:0] tag);
    logic [35:0] e;
    n_vec++;
    if ($countones(rr) > 1) begin
      n_err++;
      $display("FAIL onehot_ready dut%0d: got %b want at most one bit set", d, rr);
    end
    for (int i = 0; i < n; i++) begin
      int k;
      k = d*4 + i;
      if (rst) begin
        sbq[k].delete();
        stall_v[k] = 1'b0;
      end else begin
        if (rv[i] && rr[i]) begin
          n_vec++;
          if (rsv[i] && !rsr[i]) begin
            n_err++;
            $display("FAIL fire_into_stall dut%0d req%0d: got fire want none", d, i);
          end
          sbq[k].push_back({exp_res[k], exp_tag[k]});
        end
        if (stall_v[k]) begin
          n_vec++;
          if (!rsv[i] || {res[i], tag[i]} !== stall_d[k]) begin
            n_err++;
            $display("FAIL stall_hold dut%0d req%0d: got %b/%h want 1/%h", d, i, rsv[i],
                     {res[i], tag[i]}, stall_d[k]);
          end
        end
        stall_v[k] = rsv[i] && !rsr[i];
        stall_d[k] = {res[i], tag[i]};
        if (rsv[i] && rsr[i]) begin
          n_vec++;
          if (sbq[k].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_rsp dut%0d req%0d: got %h want none", d, i, {res[i], tag[i]});
          end else begin
            e = sbq[k].pop_front();
            if ({res[i], tag[i]} !== e) begin
              n_err++;
              $display("FAIL rsp dut%0d req%0d: got result/tag %h want %h", d, i, {res[i], tag[i]}, e);
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 2, reset, {2'b0, r2_valid}, {2'b0, r2_ready}, {2'b0, s2_valid}, {2'b0, s2_ready},
        {64'b0, s2_result}, {8'b0, s2_tag});
    mon(1, 4, reset, r4_valid, r4_ready, s4_valid, s4_ready, s4_result, s4_tag);
  end

  initial begin
    for (int i = 0; i < 2; i++) req2(i, 1'b0, ALU_ADD, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) req4(i, 1'b0, ALU_ADD, '0, '0, '0, '0);
    s2_ready = '0;
    s4_ready = '0;
    step();

    // Reset state, with a request already presented that must not be accepted.
    req2(0, 1'b1, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12);
    s2_ready = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(r2_ready), 32'h0);
    chk("rst_rsp_valid", 32'(s2_valid), 32'h0);
    chk("rst_rsp_result", s2_result[0], 32'h0);
    chk("rst_alu_a", alu2_a, 32'h0);
    chk("rst_alu_op", 32'(alu2_op), 32'(ALU_ADD));
    chk("rst_ready4", 32'(r4_ready), 32'h0);
    step();
    reset = 1'b0;

    // Single request: accepted same cycle, result next cycle, gone the cycle after.
    @(negedge clk);
    chk("t1_ready", 32'(r2_ready), 32'h1);
    chk("t1_alu_a", alu2_a, 32'd5);
    chk("t1_alu_b", alu2_b, 32'd7);
    step();
    r2_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", 32'(s2_valid), 32'h1);
    chk("t1_rsp_result", s2_result[0], 32'd12);
    chk("t1_rsp_tag", 32'(s2_tag[0]), 32'd3);
    step();
    @(negedge clk);
    chk("t1_drain", 32'(s2_valid), 32'h0);
    step();

    // Contention after a fresh reset: grants alternate starting at requester 0.
    reset = 1'b1;
    req2(0, 1'b1, ALU_SUB, 32'd10, 32'd3, 4'd1, 32'd7);
    req2(1, 1'b1, ALU_SRA, 32'h80000000, 32'd4, 4'd2, 32'hF8000000);
    @(negedge clk);
    chk("t2_rst_ready", 32'(r2_ready), 32'h0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_grant", 32'(r2_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      step();
    end
    r2_valid = '0;
    step();
    step();

    // Backpressure on requester 0 while requester 1 keeps issuing.
    req2(0, 1'b1, ALU_SLT, 32'hFFFFFFFF, 32'h0, 4'd4, 32'd1);
    req2(1, 1'b1, ALU_ADD, 32'd1, 32'd1, 4'd5, 32'd2);
    @(negedge clk);
    chk("t3_first", 32'(r2_ready), 32'h1);
    step();
    s2_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t3_bp_ready", 32'(r2_ready), 32'h2);
      chk("t3_hold_valid", 32'(s2_valid[0]), 32'h1);
      chk("t3_hold_result", s2_result[0], 32'd1);
      step();
    end
    s2_ready = 2'b11;
    req2(0, 1'b1, ALU_SLT, 32'hFFFFFFFF, 32'h0, 4'd6, 32'd1);
    @(negedge clk);
    chk("t3_regrant", 32'(r2_ready), 32'h1);
    step();
    r2_valid = '0;
    @(negedge clk);
    chk("t3_refill_valid", 32'(s2_valid[0]), 32'h1);
    chk("t3_refill_tag", 32'(s2_tag[0]), 32'd6);
    step();
    step();

    // Back-to-back issue from requester 1 alone.
    for (int c = 0; c < 3; c++) begin
      req2(1, 1'b1, t4_op[c], t4_a[c], t4_b[c], 4'(7 + c), t4_e[c]);
      @(negedge clk);
      chk("t4_ready", 32'(r2_ready), 32'h2);
      if (c > 0) chk("t4_no_bubble", 32'(s2_valid[1]), 32'h1);
      step();
    end
    r2_valid = '0;
    @(negedge clk);
    chk("t4_tail_valid", 32'(s2_valid[1]), 32'h1);
    chk("t4_tail_result", s2_result[1], 32'h0);
    chk("t4_tail_tag", 32'(s2_tag[1]), 32'd9);
    step();

    // Reset with both responses pending.
    s2_ready = 2'b00;
    req2(0, 1'b1, ALU_ADD, 32'd1, 32'd2, 4'd1, 32'd3);
    req2(1, 1'b1, ALU_ADD, 32'd3, 32'd4, 4'd2, 32'd7);
    @(negedge clk);
    chk("t5_g0", 32'(r2_ready), 32'h1);
    step();
    @(negedge clk);
    chk("t5_g1", 32'(r2_ready), 32'h2);
    step();
    @(negedge clk);
    chk("t5_none", 32'(r2_ready), 32'h0);
    chk("t5_pending", 32'(s2_valid), 32'h3);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", 32'(r2_ready), 32'h0);
    chk("t5_rst_alu_a", alu2_a, 32'h0);
    step();
    reset = 1'b0;
    s2_ready = 2'b11;
    @(negedge clk);
    chk("t5_cleared", 32'(s2_valid), 32'h0);
    chk("t5_ptr", 32'(r2_ready), 32'h1);
    step();
    @(negedge clk);
    chk("t5_second", 32'(r2_ready), 32'h2);
    step();
    r2_valid = '0;
    step();
    step();

    // Four-way fairness, with idle ALU drive before and after.
    @(negedge clk);
    chk("t6_idle_a", alu4_a, 32'h0);
    chk("t6_idle_b", alu4_b, 32'h0);
    chk("t6_idle_op", 32'(alu4_op), 32'(ALU_ADD));
    step();
    s4_ready = 4'hF;
    for (int i = 0; i < 4; i++) req4(i, 1'b1, ALU_ADD, 32'(i + 1), 32'd10, 4'(i), 32'(i + 11));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t6_grant", 32'(r4_ready), 32'(1 << (c % 4)));
      chk("t6_alu_a", alu4_a, 32'((c % 4) + 1));
      step();
    end
    r4_valid = '0;
    @(negedge clk);
    chk("t6_after_op", 32'(alu4_op), 32'(ALU_ADD));
    chk("t6_after_a", alu4_a, 32'h0);
    step();
    step();

    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (sbq[k].size() != 0) begin
        n_err++;
        $display("FAIL missing_rsp slot%0d: got %0d outstanding want 0", k, sbq[k].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
